// File: rtl/ahb_lite_pkg.sv
// Shared constants and payload types for the AHB-Lite command-stream initiator.
package ahb_lite_pkg;

  localparam int unsigned AHB_ADDR_W = 8;
  localparam int unsigned AHB_DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HSIZE_BYTE    = 2'd0;
  localparam logic [1:0] HSIZE_HALF    = 2'd1;
  localparam logic [1:0] HSIZE_WORD    = 2'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_ERR        = 2'd1,
    ST_CANCEL_RSP = 2'd2
  } state_e;

  // Address-phase slot: a full command.
  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [AHB_ADDR_W-1:0] addr;
    logic [1:0]            size;
    logic [AHB_DATA_W-1:0] wdata;
  } slot_t;

  // Data-phase slot: only the fields the data phase still needs.
  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [1:0]            offset;
    logic [1:0]            size;
    logic [AHB_DATA_W-1:0] wdata;
  } dslot_t;

  function automatic logic cmd_legal(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      HSIZE_BYTE: cmd_legal = 1'b1;
      HSIZE_HALF: cmd_legal = !offset[0];
      HSIZE_WORD: cmd_legal = (offset == 2'b00);
      default:    cmd_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// Byte-lane steering for a 32-bit bus: right-justified data <-> lane-placed data.
module ahb_lane_steer
  import ahb_lite_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [31:0] bus_wdata_c,
  output logic [31:0] rdata_c
);

  always_comb begin
    bus_wdata_c = '0;
    rdata_c     = '0;
    case (size)
      HSIZE_BYTE: begin
        bus_wdata_c[{offset, 3'b000} +: 8] = wdata[7:0];
        rdata_c[7:0]                       = bus_rdata[{offset, 3'b000} +: 8];
      end
      HSIZE_HALF: begin
        bus_wdata_c[{offset[1], 4'b0000} +: 16] = wdata[15:0];
        rdata_c[15:0]                           = bus_rdata[{offset[1], 4'b0000} +: 16];
      end
      default: begin
        bus_wdata_c = wdata;
        rdata_c     = bus_rdata;
      end
    endcase
  end

endmodule

// File: rtl/ahb_lite_master_cdl.sv
// AHB-Lite single-transfer initiator: valid/ready commands in, ordered responses out.
module ahb_lite_master_cdl
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = AHB_ADDR_W,
  parameter int unsigned DATA_W = AHB_DATA_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        hsize,
  output logic [1:0]        htrans,
  output logic [2:0]        hburst,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hresp,
  input  logic              hready
);

  state_e            state_q, state_d;
  slot_t             a_q, a_d, cmd_slot_c;
  dslot_t            d_q, d_d;
  logic              cancel_q, cancel_d;
  logic              rsp_valid_d, rsp_error_d;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              cmd_ok_c, accept_c, err_first_c;
  logic [31:0]       d_wdata_lane_c, d_rdata_ext_c;

  ahb_lane_steer u_steer (
    .size        (d_q.size),
    .offset      (d_q.offset),
    .wdata       (d_q.wdata),
    .bus_rdata   (hrdata),
    .bus_wdata_c (d_wdata_lane_c),
    .rdata_c     (d_rdata_ext_c)
  );

  // Illegal commands wait for an empty pipeline so their response stays in order.
  assign cmd_ok_c    = cmd_legal(cmd_size, cmd_addr[1:0]);
  assign err_first_c = (state_q == ST_RUN) && d_q.valid && hresp && !hready;
  assign cmd_ready   = (state_q == ST_RUN) &&
                       (cmd_ok_c ? (!a_q.valid || hready) : (!a_q.valid && !d_q.valid));
  assign accept_c    = cmd_valid && cmd_ready;

  always_comb begin
    cmd_slot_c       = '0;
    cmd_slot_c.valid = accept_c && cmd_ok_c;
    cmd_slot_c.write = cmd_write;
    cmd_slot_c.addr  = cmd_addr;
    cmd_slot_c.size  = cmd_size;
    cmd_slot_c.wdata = cmd_wdata;
  end

  // First ERROR cycle pulls the pending address phase off the bus immediately.
  assign hsel   = a_q.valid && !err_first_c;
  assign htrans = hsel ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hburst = HBURST_SINGLE;
  assign haddr  = a_q.addr;
  assign hsize  = a_q.size;
  assign hwrite = a_q.write;
  assign hwdata = (d_q.valid && d_q.write) ? d_wdata_lane_c : '0;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    d_d         = d_q;
    cancel_d    = cancel_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_RUN: begin
        if (accept_c && !cmd_ok_c) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
        end
        if (err_first_c) begin
          state_d   = ST_ERR;
          cancel_d  = a_q.valid || cmd_slot_c.valid;
          a_d.valid = 1'b0;
        end else if (hready) begin
          d_d.valid  = a_q.valid;
          d_d.write  = a_q.write;
          d_d.offset = a_q.addr[1:0];
          d_d.size   = a_q.size;
          d_d.wdata  = a_q.wdata;
          a_d.valid  = 1'b0;
          if (cmd_slot_c.valid) a_d = cmd_slot_c;
          if (d_q.valid) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = hresp;
            rsp_rdata_d = (hresp || d_q.write) ? '0 : d_rdata_ext_c;
          end
        end else if (cmd_slot_c.valid) begin
          a_d = cmd_slot_c;
        end
      end
      ST_ERR: begin
        if (hready) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          d_d.valid   = 1'b0;
          state_d     = cancel_q ? ST_CANCEL_RSP : ST_RUN;
        end
      end
      ST_CANCEL_RSP: begin
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b1;
        cancel_d    = 1'b0;
        state_d     = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_RUN;
      a_q       <= '0;
      d_q       <= '0;
      cancel_q  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      d_q       <= d_d;
      cancel_q  <= cancel_d;
      rsp_valid <= rsp_valid_d;
      rsp_error <= rsp_error_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_cdl.sv
// Self-checking bench: directed vector table, corner sequences, randomized traffic vs. a memory model.
module tb_ahb_lite_master_cdl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        hsel, hwrite, hresp, hready;
  logic [7:0]  haddr;
  logic [1:0]  hsize, htrans;
  logic [2:0]  hburst;
  logic [31:0] hwdata, hrdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_lite_master_cdl dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .hsel(hsel), .haddr(haddr), .hsize(hsize), .htrans(htrans), .hburst(hburst),
    .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata), .hresp(hresp), .hready(hready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic v, input logic w, input logic [7:0] a,
                           input logic [1:0] s, input logic [31:0] d);
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
  endtask

  typedef struct {
    logic        write;
    logic        illegal;
    logic [7:0]  addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    logic        bus_err;
    int          waits;
    logic [31:0] exp_hwdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic w, input logic ill, input logic [7:0] a, input logic [1:0] s,
                              input logic [31:0] wd, input logic [31:0] brd, input logic berr,
                              input int wt, input logic [31:0] ehw, input logic [31:0] erd,
                              input logic eerr);
    vec_t v;
    v.write = w; v.illegal = ill; v.addr = a; v.size = s; v.wdata = wd; v.bus_rdata = brd;
    v.bus_err = berr; v.waits = wt; v.exp_hwdata = ehw; v.exp_rdata = erd; v.exp_err = eerr;
    return v;
  endfunction

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    drive_cmd(1'b1, v.write, v.addr, v.size, v.wdata);
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    #1 check($sformatf("vec%0d_ready", i), cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    if (v.illegal) begin
      check($sformatf("vec%0d_illegal_rsp", i), {htrans, rsp_valid, rsp_error, rsp_rdata},
            {2'b00, 1'b1, 1'b1, 32'h0});
      @(negedge clk);
      #1 check($sformatf("vec%0d_single_rsp", i), rsp_valid, 1'b0);
      return;
    end
    check($sformatf("vec%0d_addr_phase", i), {htrans, hsel, hwrite, hsize, haddr},
          {2'b10, 1'b1, v.write, v.size, v.addr});
    for (int w = 0; w < v.waits; w++) begin
      @(negedge clk);
      hready = 1'b0; hrdata = 32'hBAD0BAD0;
      #1 check($sformatf("vec%0d_wait%0d", i, w), {hwdata, htrans, haddr, hsize, rsp_valid},
               {v.exp_hwdata, 2'b00, v.addr, v.size, 1'b0});
    end
    @(negedge clk);
    hready = 1'b1; hresp = v.bus_err; hrdata = v.bus_rdata;
    #1 check($sformatf("vec%0d_hwdata", i), hwdata, v.exp_hwdata);
    @(negedge clk);
    hresp = 1'b0; hrdata = 32'h0;
    #1 check($sformatf("vec%0d_rsp", i), {rsp_valid, rsp_error, rsp_rdata},
             {1'b1, v.exp_err, v.exp_rdata});
  endtask

  task automatic seq_b2b();
    @(negedge clk);
    drive_cmd(1'b1, 1'b1, 8'h02, 2'd1, 32'h00001234); hready = 1'b1;
    #1 check("b2b_ready0", cmd_ready, 1'b1);
    @(negedge clk);
    drive_cmd(1'b1, 1'b0, 8'h00, 2'd2, 32'h0);
    #1 check("b2b_wr_addr", {htrans, haddr, hwrite, cmd_ready}, {2'b10, 8'h02, 1'b1, 1'b1});
    @(negedge clk);
    cmd_valid = 1'b0;
    #1 check("b2b_overlap", {hwdata, htrans, haddr, hwrite}, {32'h12340000, 2'b10, 8'h00, 1'b0});
    @(negedge clk);
    hrdata = 32'h89ABCDEF;
    #1 check("b2b_rsp_wr", {rsp_valid, rsp_error, rsp_rdata, hwdata}, {1'b1, 1'b0, 32'h0, 32'h0});
    @(negedge clk);
    hrdata = 32'h0;
    #1 check("b2b_rsp_rd", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, 1'b0, 32'h89ABCDEF});
    @(negedge clk);
    #1 check("b2b_idle", rsp_valid, 1'b0);
  endtask

  task automatic seq_err();
    logic saw08;
    saw08 = 1'b0;
    @(negedge clk);
    drive_cmd(1'b1, 1'b1, 8'h04, 2'd2, 32'h00000055); hready = 1'b1; hresp = 1'b0;
    #1;
    @(negedge clk);
    drive_cmd(1'b1, 1'b0, 8'h08, 2'd2, 32'h0);
    #1 check("err_wr_addr", {htrans, haddr}, {2'b10, 8'h04});
    @(negedge clk);
    cmd_valid = 1'b0; hready = 1'b0; hresp = 1'b1;
    #1 check("err_first_idle", {htrans, hsel, cmd_ready}, {2'b00, 1'b0, 1'b0});
    if (htrans == 2'b10 && haddr == 8'h08) saw08 = 1'b1;
    @(negedge clk);
    hready = 1'b1; hresp = 1'b1;
    #1 check("err_second", {htrans, hsel, cmd_ready, rsp_valid}, {2'b00, 1'b0, 1'b0, 1'b0});
    if (htrans == 2'b10 && haddr == 8'h08) saw08 = 1'b1;
    @(negedge clk);
    hresp = 1'b0;
    #1 check("err_rsp_xfer", {rsp_valid, rsp_error, rsp_rdata, htrans, cmd_ready},
             {1'b1, 1'b1, 32'h0, 2'b00, 1'b0});
    if (htrans == 2'b10 && haddr == 8'h08) saw08 = 1'b1;
    @(negedge clk);
    #1 check("err_rsp_cancel", {rsp_valid, rsp_error, rsp_rdata, htrans, cmd_ready},
             {1'b1, 1'b1, 32'h0, 2'b00, 1'b1});
    @(negedge clk);
    #1 check("err_done", {rsp_valid, htrans}, {1'b0, 2'b00});
    check("err_no_0x08_on_bus", saw08, 1'b0);
  endtask

  task automatic seq_rst();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    drive_cmd(1'b1, 1'b0, 8'h0C, 2'd2, 32'h0); hready = 1'b1;
    #1;
    @(negedge clk);
    drive_cmd(1'b1, 1'b0, 8'h10, 2'd2, 32'h0);
    #1;
    @(negedge clk);
    cmd_valid = 1'b0; hready = 1'b0;
    #1 check("rst_pre", {htrans, haddr}, {2'b10, 8'h10});
    #1 n_rst = 1'b0;
    #1 check("rst_mid_idle", {hsel, htrans, rsp_valid, haddr, hwdata}, 64'h0);
    @(negedge clk);
    n_rst = 1'b1; hready = 1'b1; hrdata = 32'hFFFFFFFF;
    for (int c = 0; c < 5; c++) begin
      #1 if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    hrdata = 32'h0;
    check("rst_no_stale_rsp", seen, 1'b0);
  endtask

  // Randomized traffic: the bench keeps a byte-addressed reference memory and a separate
  // slave memory that only ever sees what appears on the bus.
  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t        expq[$];
  logic [7:0]  refmem[256];
  logic [7:0]  smem[256];

  task automatic push_ref();
    exp_t e;
    int   n;
    logic legal;
    n = 1 << cmd_size;
    legal = (cmd_size != 2'd3) && ((int'(cmd_addr) % n) == 0);
    e.rdata = 32'h0; e.err = 1'b0;
    if (!legal || cmd_addr >= 8'hF0) e.err = 1'b1;
    else if (cmd_write) begin
      for (int j = 0; j < n; j++) refmem[int'(cmd_addr) + j] = cmd_wdata[8*j +: 8];
    end else begin
      for (int j = 0; j < n; j++) e.rdata = e.rdata | (32'(refmem[int'(cmd_addr) + j]) << (8*j));
    end
    expq.push_back(e);
  endtask

  task automatic run_random();
    bit         pend, dp_v, dp_w;
    logic [7:0] dp_a, a;
    logic [1:0] dp_s, s;
    int         wa, lane, bad;
    exp_t       e;
    pend = 0; dp_v = 0; dp_w = 0; dp_a = 0; dp_s = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      hready = dp_v ? (($urandom % 3) != 0) : 1'b1;
      hresp  = hready && dp_v && (dp_a >= 8'hF0);
      wa     = int'({dp_a[7:2], 2'b00});
      if (hready && dp_v && !dp_w && dp_a < 8'hF0)
        hrdata = {smem[wa+3], smem[wa+2], smem[wa+1], smem[wa]};
      else
        hrdata = $urandom;
      if (!pend && cyc < 3700 && ($urandom % 4) != 0) begin
        s = (($urandom % 16) == 0) ? 2'd3 : 2'(($urandom % 3));
        a = (($urandom % 8) == 0) ? 8'(8'hF0 + ($urandom % 16)) : 8'($urandom % 32);
        if (($urandom % 8) != 0) begin
          if (s == 2'd1) a[0] = 1'b0;
          if (s == 2'd2) a[1:0] = 2'b00;
        end
        drive_cmd(1'b1, 1'($urandom % 2), a, s, $urandom);
        pend = 1;
      end
      cmd_valid = pend;
      #1;
      if (rsp_valid) begin
        if (expq.size() == 0) check("rnd_unexpected_rsp", rsp_valid, 1'b0);
        else begin
          e = expq.pop_front();
          check("rnd_rsp", {rsp_error, rsp_rdata}, {e.err, e.rdata});
        end
      end
      if (cmd_valid && cmd_ready) begin
        push_ref();
        pend = 0;
      end
      if (dp_v && hready) begin
        if (dp_w && dp_a < 8'hF0)
          for (int j = 0; j < (1 << dp_s); j++) begin
            lane = int'(dp_a[1:0]) + j;
            smem[int'(dp_a) + j] = hwdata[8*lane +: 8];
          end
        dp_v = 0;
      end
      if (hready && htrans == 2'b10) begin
        dp_v = 1; dp_w = hwrite; dp_a = haddr; dp_s = hsize;
      end
    end
    cmd_valid = 1'b0;
    check("rnd_drain", 64'(expq.size()), 64'h0);
    bad = 0;
    for (int k = 0; k < 256; k++) if (smem[k] !== refmem[k]) bad++;
    check("rnd_mem_image", 64'(bad), 64'h0);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      refmem[k] = 8'($urandom);
      smem[k]   = refmem[k];
    end
    n_rst = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    drive_cmd(1'b0, 1'b0, 8'h00, 2'd0, 32'h0);
    vecs[0]  = mk(1, 0, 8'h00, 2, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0, 0);
    vecs[1]  = mk(0, 0, 8'h02, 0, 0, 32'h00AB0000, 0, 3, 0, 32'h000000AB, 0);
    vecs[2]  = mk(1, 0, 8'h03, 0, 32'hFFFFFF5A, 0, 0, 0, 32'h5A000000, 0, 0);
    vecs[3]  = mk(1, 0, 8'h01, 0, 32'h12345677, 0, 0, 1, 32'h00007700, 0, 0);
    vecs[4]  = mk(1, 0, 8'h02, 1, 32'hABCD1234, 0, 0, 0, 32'h12340000, 0, 0);
    vecs[5]  = mk(1, 0, 8'h00, 1, 32'hABCD1234, 0, 0, 2, 32'h00001234, 0, 0);
    vecs[6]  = mk(0, 0, 8'h06, 1, 0, 32'hCAFEF00D, 0, 0, 0, 32'h0000CAFE, 0);
    vecs[7]  = mk(0, 0, 8'h04, 1, 0, 32'hCAFEF00D, 0, 1, 0, 32'h0000F00D, 0);
    vecs[8]  = mk(0, 0, 8'h09, 0, 0, 32'h11223344, 0, 0, 0, 32'h00000033, 0);
    vecs[9]  = mk(0, 0, 8'hFF, 0, 0, 32'h11223344, 0, 0, 0, 32'h00000011, 0);
    vecs[10] = mk(0, 0, 8'h10, 2, 0, 32'h11223344, 0, 1, 0, 32'h11223344, 0);
    vecs[11] = mk(0, 0, 8'h14, 2, 0, 32'h55667788, 1, 0, 0, 32'h0, 1);
    vecs[12] = mk(1, 0, 8'h18, 2, 32'hA5A5A5A5, 0, 1, 2, 32'hA5A5A5A5, 32'h0, 1);
    vecs[13] = mk(0, 1, 8'h00, 3, 0, 0, 0, 0, 0, 0, 1);
    vecs[14] = mk(1, 1, 8'h01, 1, 32'hFFFF, 0, 0, 0, 0, 0, 1);
    vecs[15] = mk(0, 1, 8'h02, 2, 0, 0, 0, 0, 0, 0, 1);
    vecs[16] = mk(1, 1, 8'h03, 2, 32'h1, 0, 0, 0, 0, 0, 1);

    repeat (2) @(negedge clk);
    #1 check("reset_ctrl", {hsel, htrans, hburst, hwrite, hsize, haddr, rsp_valid, rsp_error}, 64'h0);
    check("reset_data", {hwdata, rsp_rdata}, 64'h0);
    @(negedge clk);
    n_rst = 1'b1;
    #1 check("reset_cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 17; i++) run_vec(i);
    seq_b2b();
    seq_err();
    seq_rst();
    run_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
